// File: rtl/billiard_pkg.sv
// -----------------------------------------------------------------------------
// billiard_pkg
// Shared types and constants for the per-ball motion engine.
//   - motion_state_e : IDLE / MOVING / SINKING / SUNK
//   - VEL_W          : width of a signed velocity / integer position word
//   - FRAC_BITS_DEF  : default number of fractional bits
//   - vel_t / pos_t  : signed velocity and extended-precision position types
//   - sat_vel()      : symmetric velocity saturation helper
// -----------------------------------------------------------------------------
package billiard_pkg;

   localparam int FRAC_BITS_DEF = 4;
   localparam int VEL_W         = 11;
   localparam int POS_W         = VEL_W + FRAC_BITS_DEF;

   typedef logic signed [VEL_W-1:0] vel_t;
   typedef logic signed [POS_W-1:0] pos_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MOVING  = 2'd1,
      SINKING = 2'd2,
      SUNK    = 2'd3
   } motion_state_e;

   localparam vel_t VEL_ZERO = 11'sd0;

   // Clip a velocity into [-lim, +lim]; lim is assumed non-negative.
   function automatic vel_t sat_vel(input vel_t v, input vel_t lim);
      vel_t r;
      if (v > lim) begin
         r = lim;
      end else if (v < -lim) begin
         r = -lim;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/ball_motion_friction_step.sv
// -----------------------------------------------------------------------------
// friction_step
// Combinational per-axis friction: moves a signed velocity STEP units toward
// zero and stops at zero instead of crossing it.
//   vel_in   in   signed velocity before friction
//   vel_out  out  signed velocity after friction
// -----------------------------------------------------------------------------
module friction_step
   import billiard_pkg::*;
#(
   parameter int STEP = 1
) (
   input  logic signed [VEL_W-1:0] vel_in,
   output logic signed [VEL_W-1:0] vel_out
);

   localparam vel_t STEP_V = vel_t'(STEP);

   // Magnitude decrement; anything within one step of zero lands on zero.
   always_comb begin
      vel_out = VEL_ZERO;
      if (vel_in > STEP_V) begin
         vel_out = vel_in - STEP_V;
      end else if (vel_in < -STEP_V) begin
         vel_out = vel_in + STEP_V;
      end else begin
         vel_out = VEL_ZERO;
      end
   end

endmodule

// File: rtl/ball_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
// Per-ball motion engine. Holds fixed-point position and velocity, advances
// them once per frame, applies cue shots, collision velocity replacement,
// friction and the sink / respawn sequence.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   startOfFrame                one-clk per-frame update strobe
//   collisionOccurred, velXIn/velYIn   collision replacement velocity
//   holeHit, holeNum            ball entered hole <holeNum>
//   shoot, shootVelX/shootVelY  cue strobe and cue velocity
//   respawn                     leave SUNK
//   topLeftPosX/topLeftPosY     integer part of position
//   velX/velY                   current velocity
//   ballMoving, ballVisible, ballSunk, sunkHoleNum   status (registered)
// -----------------------------------------------------------------------------
module ball_motion
   import billiard_pkg::*;
#(
   parameter int FRAC_BITS       = FRAC_BITS_DEF,
   parameter int INIT_X          = 100,
   parameter int INIT_Y          = 200,
   parameter int MIN_X           = 0,
   parameter int MAX_X           = 623,
   parameter int MIN_Y           = 0,
   parameter int MAX_Y           = 463,
   parameter int MAX_VEL         = 255,
   parameter int FRICTION_PERIOD = 4,
   parameter int FRICTION_STEP   = 1,
   parameter int SINK_FRAMES     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    startOfFrame,
   input  logic                    collisionOccurred,
   input  logic signed [VEL_W-1:0] velXIn,
   input  logic signed [VEL_W-1:0] velYIn,
   input  logic                    holeHit,
   input  logic [2:0]              holeNum,
   input  logic                    shoot,
   input  logic signed [VEL_W-1:0] shootVelX,
   input  logic signed [VEL_W-1:0] shootVelY,
   input  logic                    respawn,
   output logic signed [VEL_W-1:0] topLeftPosX,
   output logic signed [VEL_W-1:0] topLeftPosY,
   output logic signed [VEL_W-1:0] velX,
   output logic signed [VEL_W-1:0] velY,
   output logic                    ballMoving,
   output logic                    ballVisible,
   output logic                    ballSunk,
   output logic [2:0]              sunkHoleNum
);

   localparam int POS_LW = VEL_W + FRAC_BITS;
   localparam int FX_ONE = 32'sd1 <<< FRAC_BITS;
   localparam int FC_W   = $clog2(FRICTION_PERIOD) + 32'sd1;
   localparam int SC_W   = $clog2(SINK_FRAMES) + 32'sd1;

   localparam logic signed [POS_LW-1:0] INIT_X_FX = POS_LW'(INIT_X * FX_ONE);
   localparam logic signed [POS_LW-1:0] INIT_Y_FX = POS_LW'(INIT_Y * FX_ONE);
   localparam logic signed [POS_LW:0]   MIN_X_FX  = (POS_LW+1)'(MIN_X * FX_ONE);
   localparam logic signed [POS_LW:0]   MAX_X_FX  = (POS_LW+1)'(MAX_X * FX_ONE);
   localparam logic signed [POS_LW:0]   MIN_Y_FX  = (POS_LW+1)'(MIN_Y * FX_ONE);
   localparam logic signed [POS_LW:0]   MAX_Y_FX  = (POS_LW+1)'(MAX_Y * FX_ONE);
   localparam vel_t                     MAX_VEL_V = vel_t'(MAX_VEL);

   localparam logic [FC_W-1:0] FC_ZERO = {FC_W{1'b0}};
   localparam logic [FC_W-1:0] FC_ONE  = {{(FC_W-1){1'b0}}, 1'b1};
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRICTION_PERIOD - 32'sd1);
   localparam logic [SC_W-1:0] SC_ZERO = {SC_W{1'b0}};
   localparam logic [SC_W-1:0] SC_ONE  = {{(SC_W-1){1'b0}}, 1'b1};
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SINK_FRAMES - 32'sd1);

   motion_state_e              state_q, state_d;
   logic signed [POS_LW-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   vel_t                       vel_x_q, vel_x_d, vel_y_q, vel_y_d;
   logic                       lat_full_q, lat_full_d;
   vel_t                       lat_vx_q, lat_vx_d, lat_vy_q, lat_vy_d;
   logic [FC_W-1:0]            fc_q, fc_d;
   logic [SC_W-1:0]            sc_q, sc_d;
   logic [2:0]                 hole_q, hole_d;
   logic                       moving_q, moving_d;
   logic                       visible_q, visible_d;
   logic                       sunk_q, sunk_d;

   vel_t                       shoot_vx_sat, shoot_vy_sat;
   vel_t                       col_vx_sat, col_vy_sat;
   vel_t                       vx_eff, vy_eff;
   vel_t                       vx_fric, vy_fric;
   vel_t                       vx_new, vy_new;
   logic                       fric_due;
   logic signed [POS_LW:0]     sum_x, sum_y;
   logic signed [POS_LW-1:0]   nx_pos, ny_pos;

   // Clamp a widened position sum into [lo, hi] and return it at storage width.
   function automatic logic signed [POS_LW-1:0] clamp_pos(
      input logic signed [POS_LW:0] v,
      input logic signed [POS_LW:0] lo,
      input logic signed [POS_LW:0] hi
   );
      logic signed [POS_LW:0] r;
      if (v < lo) begin
         r = lo;
      end else if (v > hi) begin
         r = hi;
      end else begin
         r = v;
      end
      return POS_LW'(r);
   endfunction

   assign shoot_vx_sat = sat_vel(shootVelX, MAX_VEL_V);
   assign shoot_vy_sat = sat_vel(shootVelY, MAX_VEL_V);
   assign col_vx_sat   = sat_vel(velXIn, MAX_VEL_V);
   assign col_vy_sat   = sat_vel(velYIn, MAX_VEL_V);

   // Velocity used for this frame's move: a latched collision replaces the current one.
   always_comb begin
      vx_eff = vel_x_q;
      vy_eff = vel_y_q;
      if (lat_full_q) begin
         vx_eff = lat_vx_q;
         vy_eff = lat_vy_q;
      end else begin
         vx_eff = vel_x_q;
         vy_eff = vel_y_q;
      end
   end

   friction_step #(.STEP(FRICTION_STEP)) u_fric_x (.vel_in(vx_eff), .vel_out(vx_fric));
   friction_step #(.STEP(FRICTION_STEP)) u_fric_y (.vel_in(vy_eff), .vel_out(vy_fric));

   // Frame datapath: widened add so the clamp sees the true overshoot, then friction.
   always_comb begin
      fric_due = (fc_q == FC_LAST);
      sum_x    = (POS_LW+1)'(pos_x_q) + (POS_LW+1)'(vx_eff);
      sum_y    = (POS_LW+1)'(pos_y_q) + (POS_LW+1)'(vy_eff);
      nx_pos   = clamp_pos(sum_x, MIN_X_FX, MAX_X_FX);
      ny_pos   = clamp_pos(sum_y, MIN_Y_FX, MAX_Y_FX);
      if (fric_due) begin
         vx_new = vx_fric;
         vy_new = vy_fric;
      end else begin
         vx_new = vx_eff;
         vy_new = vy_eff;
      end
   end

   // State register plus all datapath and status flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pos_x_q    <= INIT_X_FX;
         pos_y_q    <= INIT_Y_FX;
         vel_x_q    <= VEL_ZERO;
         vel_y_q    <= VEL_ZERO;
         lat_full_q <= 1'b0;
         lat_vx_q   <= VEL_ZERO;
         lat_vy_q   <= VEL_ZERO;
         fc_q       <= FC_ZERO;
         sc_q       <= SC_ZERO;
         hole_q     <= 3'd0;
         moving_q   <= 1'b0;
         visible_q  <= 1'b1;
         sunk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         vel_x_q    <= vel_x_d;
         vel_y_q    <= vel_y_d;
         lat_full_q <= lat_full_d;
         lat_vx_q   <= lat_vx_d;
         lat_vy_q   <= lat_vy_d;
         fc_q       <= fc_d;
         sc_q       <= sc_d;
         hole_q     <= hole_d;
         moving_q   <= moving_d;
         visible_q  <= visible_d;
         sunk_q     <= sunk_d;
      end
   end

   // Next-state and datapath update; holeHit beats the frame update, which beats latch and shoot.
   always_comb begin
      state_d    = state_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      vel_x_d    = vel_x_q;
      vel_y_d    = vel_y_q;
      lat_full_d = lat_full_q;
      lat_vx_d   = lat_vx_q;
      lat_vy_d   = lat_vy_q;
      fc_d       = fc_q;
      sc_d       = sc_q;
      hole_d     = hole_q;
      case (state_q)
         IDLE: begin
            if (holeHit) begin
               state_d    = SINKING;
               hole_d     = holeNum;
               vel_x_d    = VEL_ZERO;
               vel_y_d    = VEL_ZERO;
               lat_full_d = 1'b0;
               fc_d       = FC_ZERO;
               sc_d       = SC_ZERO;
            end else if (shoot && ((shoot_vx_sat != VEL_ZERO) || (shoot_vy_sat != VEL_ZERO))) begin
               state_d = MOVING;
               vel_x_d = shoot_vx_sat;
               vel_y_d = shoot_vy_sat;
               fc_d    = FC_ZERO;
            end else begin
               vel_x_d = VEL_ZERO;
               vel_y_d = VEL_ZERO;
            end
         end
         MOVING: begin
            if (holeHit) begin
               state_d    = SINKING;
               hole_d     = holeNum;
               vel_x_d    = VEL_ZERO;
               vel_y_d    = VEL_ZERO;
               lat_full_d = 1'b0;
               fc_d       = FC_ZERO;
               sc_d       = SC_ZERO;
            end else if (startOfFrame) begin
               pos_x_d    = nx_pos;
               pos_y_d    = ny_pos;
               vel_x_d    = vx_new;
               vel_y_d    = vy_new;
               lat_full_d = 1'b0;
               if (fric_due) begin
                  fc_d = FC_ZERO;
               end else begin
                  fc_d = fc_q + FC_ONE;
               end
               if ((vx_new == VEL_ZERO) && (vy_new == VEL_ZERO)) begin
                  state_d = IDLE;
                  fc_d    = FC_ZERO;
               end else begin
                  state_d = MOVING;
               end
            end else if (collisionOccurred && !lat_full_q) begin
               // Only the first collision of a frame is kept.
               lat_full_d = 1'b1;
               lat_vx_d   = col_vx_sat;
               lat_vy_d   = col_vy_sat;
            end else begin
               state_d = MOVING;
            end
         end
         SINKING: begin
            if (startOfFrame) begin
               if (sc_q == SC_LAST) begin
                  state_d = SUNK;
                  sc_d    = SC_ZERO;
               end else begin
                  sc_d = sc_q + SC_ONE;
               end
            end else begin
               sc_d = sc_q;
            end
         end
         SUNK: begin
            if (respawn) begin
               state_d    = IDLE;
               pos_x_d    = INIT_X_FX;
               pos_y_d    = INIT_Y_FX;
               vel_x_d    = VEL_ZERO;
               vel_y_d    = VEL_ZERO;
               lat_full_d = 1'b0;
               fc_d       = FC_ZERO;
               sc_d       = SC_ZERO;
            end else begin
               state_d = SUNK;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status flags decoded from the next state so they register alongside it.
   always_comb begin
      moving_d  = 1'b0;
      visible_d = 1'b1;
      sunk_d    = 1'b0;
      case (state_d)
         MOVING: begin
            moving_d = 1'b1;
         end
         SUNK: begin
            visible_d = 1'b0;
            sunk_d    = 1'b1;
         end
         default: begin
            moving_d  = 1'b0;
            visible_d = 1'b1;
            sunk_d    = 1'b0;
         end
      endcase
   end

   // Integer part of the fixed-point position is a plain slice (arithmetic shift).
   assign topLeftPosX = $signed(pos_x_q[POS_LW-1:FRAC_BITS]);
   assign topLeftPosY = $signed(pos_y_q[POS_LW-1:FRAC_BITS]);
   assign velX        = vel_x_q;
   assign velY        = vel_y_q;
   assign ballMoving  = moving_q;
   assign ballVisible = visible_q;
   assign ballSunk    = sunk_q;
   assign sunkHoleNum = hole_q;

endmodule

// File: tb/tb_ball_motion.sv
// -----------------------------------------------------------------------------
// tb_ball_motion
// Directed bench for ball_motion: a table of per-clock stimulus/expected-output
// records followed by hand-written clamp, friction, sink and reset sequences.
// -----------------------------------------------------------------------------
module tb_ball_motion;

   typedef struct packed {
      logic              rst;
      logic              sof;
      logic              coll;
      logic signed [10:0] vxin;
      logic signed [10:0] vyin;
      logic              hole;
      logic [2:0]        hnum;
      logic              shoot;
      logic signed [10:0] svx;
      logic signed [10:0] svy;
      logic              resp;
   } in_t;

   typedef struct packed {
      logic signed [10:0] x;
      logic signed [10:0] y;
      logic signed [10:0] vx;
      logic signed [10:0] vy;
      logic              mv;
      logic              vis;
      logic              snk;
      logic [2:0]        hn;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } row_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              startOfFrame = 1'b0;
   logic              collisionOccurred = 1'b0;
   logic signed [10:0] velXIn = 11'sd0;
   logic signed [10:0] velYIn = 11'sd0;
   logic              holeHit = 1'b0;
   logic [2:0]        holeNum = 3'd0;
   logic              shoot = 1'b0;
   logic signed [10:0] shootVelX = 11'sd0;
   logic signed [10:0] shootVelY = 11'sd0;
   logic              respawn = 1'b0;
   logic signed [10:0] topLeftPosX, topLeftPosY, velX, velY;
   logic              ballMoving, ballVisible, ballSunk;
   logic [2:0]        sunkHoleNum;

   int passed = 0;
   int total  = 0;

   ball_motion dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .collisionOccurred(collisionOccurred), .velXIn(velXIn), .velYIn(velYIn),
      .holeHit(holeHit), .holeNum(holeNum), .shoot(shoot),
      .shootVelX(shootVelX), .shootVelY(shootVelY), .respawn(respawn),
      .topLeftPosX(topLeftPosX), .topLeftPosY(topLeftPosY),
      .velX(velX), .velY(velY), .ballMoving(ballMoving),
      .ballVisible(ballVisible), .ballSunk(ballSunk), .sunkHoleNum(sunkHoleNum)
   );

   always #5 clk = ~clk;

   function automatic in_t mk_in(input int rst, input int sof, input int coll,
                                 input int vxin, input int vyin, input int hole,
                                 input int hn, input int sh, input int svx,
                                 input int svy, input int resp);
      in_t r;
      r.rst = 1'(rst);   r.sof = 1'(sof);     r.coll = 1'(coll);
      r.vxin = 11'(vxin); r.vyin = 11'(vyin); r.hole = 1'(hole);
      r.hnum = 3'(hn);   r.shoot = 1'(sh);    r.svx = 11'(svx);
      r.svy = 11'(svy);  r.resp = 1'(resp);
      return r;
   endfunction

   function automatic out_t mk_out(input int x, input int y, input int vx, input int vy,
                                   input int mv, input int vis, input int snk, input int hn);
      out_t r;
      r.x = 11'(x);   r.y = 11'(y);   r.vx = 11'(vx); r.vy = 11'(vy);
      r.mv = 1'(mv);  r.vis = 1'(vis); r.snk = 1'(snk); r.hn = 3'(hn);
      return r;
   endfunction

   function automatic in_t f_nop();
      return mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic in_t f_rst();
      return mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic in_t f_sof();
      return mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic in_t f_shoot(input int x, input int y);
      return mk_in(0, 0, 0, 0, 0, 0, 0, 1, x, y, 0);
   endfunction
   function automatic in_t f_coll(input int x, input int y);
      return mk_in(0, 0, 1, x, y, 0, 0, 0, 0, 0, 0);
   endfunction

   // Drive one clock of stimulus on the falling edge, check outputs just after the rising edge.
   task automatic run(input in_t s, input out_t e, input string tag);
      out_t a;
      @(negedge clk);
      reset = s.rst; startOfFrame = s.sof; collisionOccurred = s.coll;
      velXIn = s.vxin; velYIn = s.vyin; holeHit = s.hole; holeNum = s.hnum;
      shoot = s.shoot; shootVelX = s.svx; shootVelY = s.svy; respawn = s.resp;
      @(posedge clk);
      #1;
      a.x = topLeftPosX; a.y = topLeftPosY; a.vx = velX; a.vy = velY;
      a.mv = ballMoving; a.vis = ballVisible; a.snk = ballSunk; a.hn = sunkHoleNum;
      total++;
      if (a !== e) begin
         $display("FAIL %s: got x=%0d y=%0d vx=%0d vy=%0d mv=%0b vis=%0b snk=%0b hole=%0d, want x=%0d y=%0d vx=%0d vy=%0d mv=%0b vis=%0b snk=%0b hole=%0d",
                  tag, $signed(a.x), $signed(a.y), $signed(a.vx), $signed(a.vy), a.mv, a.vis, a.snk, a.hn,
                  $signed(e.x), $signed(e.y), $signed(e.vx), $signed(e.vy), e.mv, e.vis, e.snk, e.hn);
      end else begin
         passed++;
      end
   endtask

   row_t tbl [14];

   initial begin
      in_t s;
      int ax  [8] = '{84, 68, 52, 36, 20, 4, 0, 0};
      int avx [8] = '{-255, -255, -255, -254, -254, -254, -254, -253};
      int bvx [8] = '{2, 2, 2, 1, 1, 1, 1, 0};

      // Shoot, four frames with friction, first-collision-wins latch, saturated collision.
      tbl[0]  = '{f_rst(),             mk_out(100, 200,    0,  0, 0, 1, 0, 0)};
      tbl[1]  = '{f_shoot(32, 0),      mk_out(100, 200,   32,  0, 1, 1, 0, 0)};
      tbl[2]  = '{f_sof(),             mk_out(102, 200,   32,  0, 1, 1, 0, 0)};
      tbl[3]  = '{f_sof(),             mk_out(104, 200,   32,  0, 1, 1, 0, 0)};
      tbl[4]  = '{f_sof(),             mk_out(106, 200,   32,  0, 1, 1, 0, 0)};
      tbl[5]  = '{f_sof(),             mk_out(108, 200,   31,  0, 1, 1, 0, 0)};
      tbl[6]  = '{f_coll(-32, 48),     mk_out(108, 200,   31,  0, 1, 1, 0, 0)};
      tbl[7]  = '{f_coll(80, -80),     mk_out(108, 200,   31,  0, 1, 1, 0, 0)};
      tbl[8]  = '{f_sof(),             mk_out(106, 203,  -32, 48, 1, 1, 0, 0)};
      tbl[9]  = '{f_shoot(100, 0),     mk_out(106, 203,  -32, 48, 1, 1, 0, 0)};
      tbl[10] = '{f_coll(-600, 48),    mk_out(106, 203,  -32, 48, 1, 1, 0, 0)};
      tbl[11] = '{f_sof(),             mk_out( 90, 206, -255, 48, 1, 1, 0, 0)};
      tbl[12] = '{f_sof(),             mk_out( 74, 209, -255, 48, 1, 1, 0, 0)};
      tbl[13] = '{f_sof(),             mk_out( 58, 212, -254, 47, 1, 1, 0, 0)};

      for (int i = 0; i < 14; i++) begin
         run(tbl[i].i, tbl[i].o, $sformatf("tbl%0d", i));
      end

      // Left wall: position must clamp at 0 and never wrap positive.
      run(f_rst(), mk_out(100, 200, 0, 0, 0, 1, 0, 0), "clamp_rst");
      run(f_shoot(-255, 0), mk_out(100, 200, -255, 0, 1, 1, 0, 0), "clamp_shoot");
      for (int i = 0; i < 8; i++) begin
         run(f_sof(), mk_out(ax[i], 200, avx[i], 0, 1, 1, 0, 0), $sformatf("clamp_sof%0d", i + 1));
      end

      // Friction runs a small velocity down to zero and drops back to IDLE.
      run(f_rst(), mk_out(100, 200, 0, 0, 0, 1, 0, 0), "fric_rst");
      run(f_shoot(2, 0), mk_out(100, 200, 2, 0, 1, 1, 0, 0), "fric_shoot");
      for (int i = 0; i < 8; i++) begin
         run(f_sof(), mk_out(100, 200, bvx[i], 0, (i < 7) ? 1 : 0, 1, 0, 0), $sformatf("fric_sof%0d", i + 1));
      end

      // Sink with holeHit on a frame strobe, distractions while sinking, then respawn.
      run(f_rst(), mk_out(100, 200, 0, 0, 0, 1, 0, 0), "sink_rst");
      run(f_shoot(32, 0), mk_out(100, 200, 32, 0, 1, 1, 0, 0), "sink_shoot");
      run(f_sof(), mk_out(102, 200, 32, 0, 1, 1, 0, 0), "sink_sof");
      s = f_sof(); s.hole = 1'b1; s.hnum = 3'd3;
      run(s, mk_out(102, 200, 0, 0, 0, 1, 0, 3), "sink_hit");
      for (int i = 0; i < 7; i++) begin
         s = f_sof();
         if (i == 0) begin s.shoot = 1'b1; s.svx = 11'sd50; s.svy = 11'sd50; end
         if (i == 1) begin s.coll = 1'b1; s.vxin = 11'sd90; s.vyin = 11'sd90; end
         if (i == 2) begin s.hole = 1'b1; s.hnum = 3'd5; end
         run(s, mk_out(102, 200, 0, 0, 0, 1, 0, 3), $sformatf("sinking%0d", i + 1));
      end
      run(f_sof(), mk_out(102, 200, 0, 0, 0, 0, 1, 3), "sunk");
      run(f_nop(), mk_out(102, 200, 0, 0, 0, 0, 1, 3), "sunk_hold");
      s = f_nop(); s.resp = 1'b1;
      run(s, mk_out(100, 200, 0, 0, 0, 1, 0, 3), "respawn");

      // Reset in the middle of sinking, zero shot, saturated shot.
      run(f_shoot(32, 0), mk_out(100, 200, 32, 0, 1, 1, 0, 3), "rs_shoot");
      s = f_nop(); s.hole = 1'b1; s.hnum = 3'd6;
      run(s, mk_out(100, 200, 0, 0, 0, 1, 0, 6), "rs_hit");
      run(f_sof(), mk_out(100, 200, 0, 0, 0, 1, 0, 6), "rs_sinking1");
      run(f_sof(), mk_out(100, 200, 0, 0, 0, 1, 0, 6), "rs_sinking2");
      s = f_rst(); s.shoot = 1'b1; s.svx = 11'sd40;
      run(s, mk_out(100, 200, 0, 0, 0, 1, 0, 0), "rs_reset");
      run(f_shoot(0, 0), mk_out(100, 200, 0, 0, 0, 1, 0, 0), "zero_shot");
      run(f_shoot(300, -300), mk_out(100, 200, 255, -255, 1, 1, 0, 0), "sat_shot");
      run(f_sof(), mk_out(115, 184, 255, -255, 1, 1, 0, 0), "sat_sof");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Per-ball motion engine that consumes the collision/hole outputs of the hit-detection logic, holds the ball's fixed-point position and velocity, and advances them once per video frame.
- Applies cue shots, collision velocity replacements, friction decay and the sink/respawn sequence.
- Feeds top-left position and velocity back to the hit-detection logic and the ball drawer; one instance per ball.

Parameters:
- FRAC_BITS, 4, fractional bits of position and velocity (velocity unit = 1/2^FRAC_BITS px/frame)
- INIT_X, 100, respawn/reset top-left X (integer px)
- INIT_Y, 200, respawn/reset top-left Y (integer px)
- MIN_X / MAX_X, 0 / 623, clamp range for top-left X (integer px)
- MIN_Y / MAX_Y, 0 / 463, clamp range for top-left Y (integer px)
- MAX_VEL, 255, velocity magnitude saturation (velocity units)
- FRICTION_PERIOD, 4, frames between friction steps
- FRICTION_STEP, 1, magnitude removed per friction step (velocity units)
- SINK_FRAMES, 8, frames spent in the sinking animation

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-clk pulse per frame; update strobe
- collisionOccurred  in  1  collision flag from hit detection, may pulse anywhere in the frame
- velXIn / velYIn  in  11 signed  replacement velocity, valid while collisionOccurred=1
- holeHit  in  1  ball entered a hole
- holeNum  in  3  hole index, valid with holeHit
- shoot  in  1  one-clk cue strobe
- shootVelX / shootVelY  in  11 signed  cue velocity, valid with shoot
- respawn  in  1  one-clk strobe, leaves SUNK
- topLeftPosX / topLeftPosY  out  11 signed  integer part of position
- velX / velY  out  11 signed  current velocity
- ballMoving  out  1  state==MOVING
- ballVisible  out  1  0 only in SUNK
- ballSunk  out  1  state==SUNK
- sunkHoleNum  out  3  hole captured on holeHit

Behaviour:
- Reset, synchronous, active-high, wins over every other input and is accepted in any state: state=IDLE, position=(INIT_X,INIT_Y), velocity=0, collision latch empty, friction counter=0, sink counter=0, sunkHoleNum=0, ballVisible=1, ballMoving=0, ballSunk=0.
- Internal position width is 11+FRAC_BITS signed; outputs are its integer part (arithmetic shift right by FRAC_BITS).
- Every loaded velocity (shoot or collision) saturates to ±MAX_VEL.
- Collision latch: the first clk in a frame with collisionOccurred=1 captures velXIn/velYIn; later pulses in the same frame are ignored. The latch clears on each startOfFrame. Collisions are latched only in MOVING.
- States:
  - IDLE: velocity=0. On shoot, load shoot velocity, go to MOVING next clk. If shoot velocity is (0,0) after saturation, stay in IDLE.
  - MOVING, on each startOfFrame, in this order:
    - if the latch is full, velocity=latched value
    - position += velocity (sign-extended), then clamp each axis to its MIN/MAX
    - friction counter++; on reaching FRICTION_PERIOD, reset the counter and reduce each axis magnitude by FRICTION_STEP, stopping at 0 (never crossing zero)
    - if both axes are 0, go to IDLE and reset the friction counter
    - shoot in MOVING is ignored
  - SINKING: entered from MOVING or IDLE on holeHit. Captures holeNum, sets velocity=0, discards the latch. Counts SINK_FRAMES startOfFrame pulses, then goes to SUNK. Ignores collision, shoot and holeHit.
  - SUNK: ballVisible=0, ballSunk=1, position held. respawn restores INIT position and zero velocity and goes to IDLE next clk.
- Priority on the same clk: reset > holeHit > startOfFrame update > collision latch > shoot.
- holeHit coinciding with startOfFrame: go to SINKING without moving.
- Latency: all outputs update on the clk after startOfFrame (registered); shoot, holeHit and respawn take effect 1 clk later.
- Velocity is never written outside these rules; there is no wrap-around, because of the clamp.

Decomposition:
- billiard_pkg:
  - motion state enum (IDLE, MOVING, SINKING, SUNK)
  - FRAC_BITS default and the velocity/position width constants
  - typedefs for the signed 11-bit velocity and the extended-precision position
- Sub-module friction_step: combinational per-axis magnitude decrement toward zero with saturation; instantiated twice.

Test Plan:
- Reset, then shoot (32,0) -> next clk MOVING; after SOF1..SOF4 topLeftPosX=102,104,106,108 and velX=31 after SOF4.
- MOVING velX=32; in one frame, collisionOccurred with velXIn=-32, then another pulse with velXIn=80 -> after SOF velX=-32, posX drops by 2; the 80 is ignored.
- Shoot (-255,0) at posX=1 -> posX clamped to 0 after SOF, no wrap to a positive value.
- Shoot (2,0) with FRICTION_STEP=1 -> velX 2→1 at SOF4, 1→0 at SOF8, then IDLE and ballMoving=0.
- holeHit holeNum=3 together with startOfFrame -> position unchanged, SINKING; after 8 SOFs ballSunk=1, ballVisible=0, sunkHoleNum=3; respawn -> next clk IDLE at (100,200), ballVisible=1.
- reset asserted mid-SINKING -> next clk IDLE, (100,200), velocity 0, sunkHoleNum=0.
